pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/bypass controller for the 5-stage RV32I pipeline.
- Detects load-use hazards, LSU wait states and EX-resolved control-flow redirects.
- Drives the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and clears, plus the regfile write-through selects in decode.
- Keeps saturating stall/flush performance counters and a sticky LSU-timeout flag.

Parameters:
- LD_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255, max consecutive LSU wait cycles before forced release (1..65535).
- PERF_W, 32, width of the stall and flush counters.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  async active-low reset
- ID_rs1_addr  in  5  rs1 of instruction in ID
- ID_rs2_addr  in  5  rs2 of instruction in ID
- ID_rd_rs2_en  in  1  ID instruction reads rs2
- EX_rd_addr  in  5  rd of instruction in EX
- EX_rd_wren  in  1  EX instruction writes rd
- EX_ld_en  in  1  EX instruction is a load
- EX_br_taken  in  1  EX redirects PC (taken branch / jump)
- MEM_req  in  1  MEM instruction accesses LSU
- MEM_ack  in  1  LSU completes the access this cycle
- WB_rd_addr  in  5  WB destination
- WB_rd_wren  in  1  WB writes regfile
- IF_en  out  1  PC and IF/ID advance
- IF_rst_n  out  1  IF/ID clear, active low
- ID_stall_en  out  1  ID/EX advance (1 = load, 0 = hold)
- ID_rst_n  out  1  ID/EX clear (bubble), active low
- EX_en  out  1  EX/MEM and MEM/WB advance
- sel_rs1_wb  out  1  decode takes WB_rd_data for rs1
- sel_rs2_wb  out  1  decode takes WB_rd_data for rs2
- mem_err_o  out  1  sticky LSU timeout flag
- stall_cnt_o  out  PERF_W  cycles with IF_en = 0, saturating
- flush_cnt_o  out  PERF_W  redirect flushes taken, saturating

Behaviour:
- Reset (async, rst_ni = 0):
  - state = RUN; counters, mem_err_o and internal counters = 0.
  - Outputs forced to IF_en = 1, ID_stall_en = 1, EX_en = 1, IF_rst_n = 1, ID_rst_n = 1.
  - Reset mid-stall returns to RUN; no pending stall survives.
- Outputs are combinational from state and inputs; all consumers sample them at the next rising edge.
- lu_haz = EX_ld_en & EX_rd_wren & (EX_rd_addr != 0) & ((EX_rd_addr == ID_rs1_addr) | (ID_rd_rs2_en & EX_rd_addr == ID_rs2_addr)).
- mem_wait = MEM_req & ~MEM_ack.
- Write-through selects:
  - sel_rs1_wb = WB_rd_wren & (WB_rd_addr != 0) & (WB_rd_addr == ID_rs1_addr).
  - sel_rs2_wb = same check against ID_rs2_addr.
  - Both are independent of state.
- States: RUN, LD_STALL, MEM_WAIT.
- Priority: mem_wait > EX_br_taken > lu_haz.
- RUN:
  - mem_wait: all enables = 0, clears = 1; next MEM_WAIT, wait_cnt = 1.
  - else EX_br_taken: IF_rst_n = 0, ID_rst_n = 0, enables = 1. The two younger instructions are killed; flush_cnt +1; stay RUN.
  - else lu_haz: IF_en = 0, ID_rst_n = 0, others = 1. One bubble is inserted. If LD_BUBBLES > 1, next LD_STALL with bub_cnt = 1.
  - else all enables = 1, clears = 1.
- LD_STALL:
  - Same outputs as the lu_haz case, held without rechecking lu_haz.
  - bub_cnt increments; when bub_cnt == LD_BUBBLES - 1, next RUN.
  - mem_wait in LD_STALL: freeze everything, go MEM_WAIT, then resume LD_STALL with bub_cnt unchanged.
- MEM_WAIT:
  - IF_en = ID_stall_en = EX_en = 0, clears = 1.
  - On MEM_ack: return to the saved state (RUN or LD_STALL). The release cycle itself behaves as in RUN/LD_STALL with the inputs seen that cycle.
  - EX_br_taken is held stable by the frozen EX; its flush happens in the release cycle.
  - If wait_cnt reaches MEM_TIMEOUT without ack: set mem_err_o (sticky until reset) and release as if acked.
- Counters:
  - stall_cnt_o increments every cycle IF_en = 0, including the reset-release cycle only if IF_en = 0.
  - flush_cnt_o increments once per cycle with IF_rst_n = 0.
  - Both saturate at all-ones and never wrap.
- x0 never causes a hazard or bypass.

Test Plan:
- lw x5 in EX and add x6,x5,x1 in ID (LD_BUBBLES = 1) -> one cycle IF_en = 0, ID_rst_n = 0; next cycle all enables 1; stall_cnt_o = 1.
- Same with LD_BUBBLES = 3 -> exactly 3 consecutive bubble cycles, then RUN; stall_cnt_o = 3.
- EX_br_taken = 1 with lu_haz also true -> IF_rst_n = 0, ID_rst_n = 0, IF_en = 1; flush_cnt_o = 1, stall_cnt_o = 0.
- MEM_req = 1, MEM_ack low 4 cycles -> 4 cycles all enables 0; ack cycle releases; stall_cnt_o = 4; mem_err_o = 0.
- MEM_TIMEOUT = 8, ack never arrives -> release after 8 wait cycles; mem_err_o = 1 and stays 1 after a later ack.
- WB_rd_addr = 7, wren = 1, ID rs1 = rs2 = 7 -> sel_rs1_wb = sel_rs2_wb = 1. Same with addr 0 -> both 0. Assert rst_ni low during MEM_WAIT -> outputs at reset values immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bypass controller for the 5-stage RV32I pipeline: load-use
// bubbles, LSU wait freeze with timeout, EX redirect flush and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned LD_BUBBLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [4:0]        ID_rs1_addr,
  input  logic [4:0]        ID_rs2_addr,
  input  logic              ID_rd_rs2_en,
  input  logic [4:0]        EX_rd_addr,
  input  logic              EX_rd_wren,
  input  logic              EX_ld_en,
  input  logic              EX_br_taken,
  input  logic              MEM_req,
  input  logic              MEM_ack,
  input  logic [4:0]        WB_rd_addr,
  input  logic              WB_rd_wren,
  output logic              IF_en,
  output logic              IF_rst_n,
  output logic              ID_stall_en,
  output logic              ID_rst_n,
  output logic              EX_en,
  output logic              sel_rs1_wb,
  output logic              sel_rs2_wb,
  output logic              mem_err_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT} state_e;

  localparam logic [2:0]  BUB_LAST = 3'(LD_BUBBLES - 1);
  localparam logic [15:0] TMO      = 16'(MEM_TIMEOUT);

  state_e            state_q, state_d, ret_q, ret_d, base;
  logic [2:0]        bub_q, bub_d;
  logic [15:0]       wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic [PERF_W-1:0] stall_q, flush_q;
  logic              lu_haz, mem_wait, timeout, hold;
  logic              if_en_c, if_rst_n_c, id_en_c, id_rst_n_c, ex_en_c;

  assign lu_haz = EX_ld_en & EX_rd_wren & (EX_rd_addr != 5'd0) &
                  ((EX_rd_addr == ID_rs1_addr) |
                   (ID_rd_rs2_en & (EX_rd_addr == ID_rs2_addr)));
  assign mem_wait = MEM_req & ~MEM_ack;
  assign timeout  = (state_q == MEM_WAIT) & ~MEM_ack & (wait_q >= TMO);

  assign sel_rs1_wb = WB_rd_wren & (WB_rd_addr != 5'd0) & (WB_rd_addr == ID_rs1_addr);
  assign sel_rs2_wb = WB_rd_wren & (WB_rd_addr != 5'd0) & (WB_rd_addr == ID_rs2_addr);

  // The release cycle out of MEM_WAIT evaluates the saved state's logic directly.
  always_comb begin
    if_en_c    = 1'b1;
    if_rst_n_c = 1'b1;
    id_en_c    = 1'b1;
    id_rst_n_c = 1'b1;
    ex_en_c    = 1'b1;
    state_d    = state_q;
    ret_d      = ret_q;
    bub_d      = bub_q;
    wait_d     = wait_q;
    mem_err_d  = mem_err_q | timeout;
    base       = (state_q == MEM_WAIT) ? ret_q : state_q;
    hold       = (state_q == MEM_WAIT) ? (~MEM_ack & ~timeout) : mem_wait;

    if (hold) begin
      if_en_c = 1'b0;
      id_en_c = 1'b0;
      ex_en_c = 1'b0;
      state_d = MEM_WAIT;
      if (state_q == MEM_WAIT) begin
        wait_d = wait_q + 16'd1;
      end else begin
        ret_d  = state_q;
        wait_d = 16'd1;
      end
    end else if (base == LD_STALL) begin
      if_en_c    = 1'b0;
      id_rst_n_c = 1'b0;
      bub_d      = bub_q + 3'd1;
      state_d    = (bub_q == BUB_LAST) ? RUN : LD_STALL;
    end else if (EX_br_taken) begin
      if_rst_n_c = 1'b0;
      id_rst_n_c = 1'b0;
      state_d    = RUN;
    end else if (lu_haz) begin
      if_en_c    = 1'b0;
      id_rst_n_c = 1'b0;
      state_d    = RUN;
      if (LD_BUBBLES > 1) begin
        state_d = LD_STALL;
        bub_d   = 3'd1;
      end
    end else begin
      state_d = RUN;
    end
  end

  // Reset forces the pipeline-enable view immediately, regardless of inputs.
  assign IF_en       = ~rst_ni | if_en_c;
  assign IF_rst_n    = ~rst_ni | if_rst_n_c;
  assign ID_stall_en = ~rst_ni | id_en_c;
  assign ID_rst_n    = ~rst_ni | id_rst_n_c;
  assign EX_en       = ~rst_ni | ex_en_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      bub_q     <= '0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      bub_q     <= bub_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      if (!if_en_c && stall_q != '1)
        stall_q <= stall_q + PERF_W'(1);
      if (!if_rst_n_c && flush_q != '1)
        flush_q <= flush_q + PERF_W'(1);
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (1 and 3 load
// bubbles, 2-bit counters) share one stimulus set.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [4:0] ID_rs1_addr, ID_rs2_addr, EX_rd_addr, WB_rd_addr;
  logic       ID_rd_rs2_en, EX_rd_wren, EX_ld_en, EX_br_taken;
  logic       MEM_req, MEM_ack, WB_rd_wren;

  logic        a_if_en, a_if_rst_n, a_id_en, a_id_rst_n, a_ex_en, a_s1, a_s2, a_err;
  logic [31:0] a_stall, a_flush;
  logic        b_if_en, b_if_rst_n, b_id_en, b_id_rst_n, b_ex_en, b_s1, b_s2, b_err;
  logic [31:0] b_stall, b_flush;
  logic        c_if_en, c_if_rst_n, c_id_en, c_id_rst_n, c_ex_en, c_s1, c_s2, c_err;
  logic [1:0]  c_stall, c_flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.LD_BUBBLES(1), .MEM_TIMEOUT(8), .PERF_W(32)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rd_rs2_en(ID_rd_rs2_en), .EX_rd_addr(EX_rd_addr), .EX_rd_wren(EX_rd_wren),
    .EX_ld_en(EX_ld_en), .EX_br_taken(EX_br_taken), .MEM_req(MEM_req), .MEM_ack(MEM_ack),
    .WB_rd_addr(WB_rd_addr), .WB_rd_wren(WB_rd_wren), .IF_en(a_if_en), .IF_rst_n(a_if_rst_n),
    .ID_stall_en(a_id_en), .ID_rst_n(a_id_rst_n), .EX_en(a_ex_en), .sel_rs1_wb(a_s1),
    .sel_rs2_wb(a_s2), .mem_err_o(a_err), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush));

  pipeline_hazard_ctrl #(.LD_BUBBLES(3), .MEM_TIMEOUT(255), .PERF_W(32)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rd_rs2_en(ID_rd_rs2_en), .EX_rd_addr(EX_rd_addr), .EX_rd_wren(EX_rd_wren),
    .EX_ld_en(EX_ld_en), .EX_br_taken(EX_br_taken), .MEM_req(MEM_req), .MEM_ack(MEM_ack),
    .WB_rd_addr(WB_rd_addr), .WB_rd_wren(WB_rd_wren), .IF_en(b_if_en), .IF_rst_n(b_if_rst_n),
    .ID_stall_en(b_id_en), .ID_rst_n(b_id_rst_n), .EX_en(b_ex_en), .sel_rs1_wb(b_s1),
    .sel_rs2_wb(b_s2), .mem_err_o(b_err), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush));

  pipeline_hazard_ctrl #(.LD_BUBBLES(1), .MEM_TIMEOUT(255), .PERF_W(2)) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rd_rs2_en(ID_rd_rs2_en), .EX_rd_addr(EX_rd_addr), .EX_rd_wren(EX_rd_wren),
    .EX_ld_en(EX_ld_en), .EX_br_taken(EX_br_taken), .MEM_req(MEM_req), .MEM_ack(MEM_ack),
    .WB_rd_addr(WB_rd_addr), .WB_rd_wren(WB_rd_wren), .IF_en(c_if_en), .IF_rst_n(c_if_rst_n),
    .ID_stall_en(c_id_en), .ID_rst_n(c_id_rst_n), .EX_en(c_ex_en), .sel_rs1_wb(c_s1),
    .sel_rs2_wb(c_s2), .mem_err_o(c_err), .stall_cnt_o(c_stall), .flush_cnt_o(c_flush));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ID_rs1_addr = '0; ID_rs2_addr = '0; ID_rd_rs2_en = 1'b0;
    EX_rd_addr = '0; EX_rd_wren = 1'b0; EX_ld_en = 1'b0; EX_br_taken = 1'b0;
    MEM_req = 1'b0; MEM_ack = 1'b0; WB_rd_addr = '0; WB_rd_wren = 1'b0;
  endtask

  // Stimulus changes at posedge+1, combinational checks at posedge+2.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic set_ld_use(input logic [4:0] rd);
    EX_ld_en = 1'b1; EX_rd_wren = 1'b1; EX_rd_addr = rd;
    ID_rs1_addr = rd; ID_rs2_addr = 5'd1; ID_rd_rs2_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle();
    rst_ni = 1'b0;
    #12;
    check_eq("rst_if_en", {31'd0, a_if_en}, 32'd1);
    check_eq("rst_clears", {30'd0, a_if_rst_n, a_id_rst_n}, 32'd3);
    check_eq("rst_en", {30'd0, a_id_en, a_ex_en}, 32'd3);
    check_eq("rst_cnt", a_stall | a_flush, 32'd0);
    check_eq("rst_err", {31'd0, a_err}, 32'd0);

    // load-use: 1 bubble on u_a, 3 bubbles on u_b
    do_reset();
    set_ld_use(5'd5);
    #1;
    check_eq("lu_a_c1", {27'd0, a_if_en, a_id_rst_n, a_id_en, a_ex_en, a_if_rst_n}, 32'b00111);
    check_eq("lu_b_c1", {30'd0, b_if_en, b_id_rst_n}, 32'd0);
    tick(); idle(); #1;
    check_eq("lu_a_c2", {27'd0, a_if_en, a_id_rst_n, a_id_en, a_ex_en, a_if_rst_n}, 32'b11111);
    check_eq("lu_a_stall", a_stall, 32'd1);
    check_eq("lu_b_c2", {30'd0, b_if_en, b_id_rst_n}, 32'd0);
    tick(); #1;
    check_eq("lu_b_c3", {30'd0, b_if_en, b_id_rst_n}, 32'd0);
    tick(); #1;
    check_eq("lu_b_c4", {30'd0, b_if_en, b_id_rst_n}, 32'd3);
    check_eq("lu_b_stall", b_stall, 32'd3);
    check_eq("lu_a_stall_end", a_stall, 32'd1);

    // hazard qualification, no clock edge involved
    set_ld_use(5'd0); #1;
    check_eq("lu_x0", {31'd0, a_if_en}, 32'd1);
    set_ld_use(5'd9); ID_rs1_addr = 5'd3; ID_rs2_addr = 5'd9; ID_rd_rs2_en = 1'b0; #1;
    check_eq("lu_rs2_unused", {31'd0, a_if_en}, 32'd1);
    ID_rd_rs2_en = 1'b1; #1;
    check_eq("lu_rs2_used", {31'd0, a_if_en}, 32'd0);
    EX_ld_en = 1'b0; #1;
    check_eq("lu_not_load", {31'd0, a_if_en}, 32'd1);

    // redirect beats load-use
    do_reset();
    set_ld_use(5'd5); EX_br_taken = 1'b1; #1;
    check_eq("br_outs", {27'd0, a_if_en, a_id_rst_n, a_id_en, a_ex_en, a_if_rst_n}, 32'b10110);
    tick(); idle(); #1;
    check_eq("br_flush", a_flush, 32'd1);
    check_eq("br_stall", a_stall, 32'd0);
    check_eq("br_b_run", {31'd0, b_if_en}, 32'd1);

    // LSU wait of 4 frozen cycles
    do_reset();
    MEM_req = 1'b1; #1;
    check_eq("mw_c1", {27'd0, a_if_en, a_id_rst_n, a_id_en, a_ex_en, a_if_rst_n}, 32'b01001);
    for (int unsigned i = 2; i <= 4; i++) begin
      tick(); #1;
      check_eq("mw_frozen", {29'd0, a_if_en, a_id_en, a_ex_en}, 32'd0);
    end
    tick(); MEM_ack = 1'b1; #1;
    check_eq("mw_release", {29'd0, a_if_en, a_id_en, a_ex_en}, 32'd7);
    tick(); idle(); #1;
    check_eq("mw_stall", a_stall, 32'd4);
    check_eq("mw_err", {31'd0, a_err}, 32'd0);
    check_eq("mw_b_stall", b_stall, 32'd4);
    check_eq("mw_sat", {30'd0, c_stall}, 32'd3);

    // redirect held during LSU wait flushes on release
    do_reset();
    MEM_req = 1'b1; EX_br_taken = 1'b1; #1;
    check_eq("mwbr_c1", {30'd0, a_if_en, a_if_rst_n}, 32'b01);
    tick(); MEM_ack = 1'b1; #1;
    check_eq("mwbr_rel", {30'd0, a_if_en, a_if_rst_n}, 32'b10);
    tick(); idle(); #1;
    check_eq("mwbr_cnt", {a_flush[15:0], a_stall[15:0]}, {16'd1, 16'd1});

    // LSU wait inside a 3-bubble stall resumes with the bubble count kept
    do_reset();
    set_ld_use(5'd5); tick(); idle();
    MEM_req = 1'b1; #1;
    check_eq("ldmw_freeze", {29'd0, b_if_en, b_id_rst_n, b_ex_en}, 32'b010);
    tick(); MEM_ack = 1'b1; #1;
    check_eq("ldmw_resume", {29'd0, b_if_en, b_id_rst_n, b_ex_en}, 32'b001);
    tick(); idle(); #1;
    check_eq("ldmw_last", {29'd0, b_if_en, b_id_rst_n, b_ex_en}, 32'b001);
    tick(); #1;
    check_eq("ldmw_run", {29'd0, b_if_en, b_id_rst_n, b_ex_en}, 32'b111);
    check_eq("ldmw_stall", b_stall, 32'd4);

    // LSU timeout after 8 wait cycles on u_a
    do_reset();
    MEM_req = 1'b1; #1;
    check_eq("to_c1", {31'd0, a_if_en}, 32'd0);
    for (int unsigned i = 2; i <= 8; i++) begin
      tick(); #1;
      check_eq("to_frozen", {31'd0, a_if_en}, 32'd0);
    end
    check_eq("to_err_pre", {31'd0, a_err}, 32'd0);
    tick(); #1;
    check_eq("to_release", {29'd0, a_if_en, a_id_en, a_ex_en}, 32'd7);
    tick(); MEM_ack = 1'b1; #1;
    check_eq("to_err", {31'd0, a_err}, 32'd1);
    check_eq("to_stall", a_stall, 32'd8);
    tick(); idle(); #1;
    check_eq("to_err_sticky", {31'd0, a_err}, 32'd1);

    // write-through selects
    WB_rd_wren = 1'b1; WB_rd_addr = 5'd7; ID_rs1_addr = 5'd7; ID_rs2_addr = 5'd7; #1;
    check_eq("byp_both", {30'd0, a_s1, a_s2}, 32'd3);
    ID_rs2_addr = 5'd8; #1;
    check_eq("byp_rs1", {30'd0, a_s1, a_s2}, 32'd2);
    WB_rd_addr = 5'd0; ID_rs1_addr = 5'd0; ID_rs2_addr = 5'd0; #1;
    check_eq("byp_x0", {30'd0, a_s1, a_s2}, 32'd0);
    WB_rd_addr = 5'd7; ID_rs1_addr = 5'd7; ID_rs2_addr = 5'd7; WB_rd_wren = 1'b0; #1;
    check_eq("byp_nowr", {30'd0, a_s1, a_s2}, 32'd0);

    // reset asserted in MEM_WAIT
    do_reset();
    MEM_req = 1'b1; tick(); tick(); #1;
    check_eq("rmw_frozen", {31'd0, a_if_en}, 32'd0);
    rst_ni = 1'b0; #1;
    check_eq("rmw_outs", {27'd0, a_if_en, a_id_rst_n, a_id_en, a_ex_en, a_if_rst_n}, 32'b11111);
    check_eq("rmw_cnt", a_stall, 32'd0);
    idle(); tick(); rst_ni = 1'b1; tick(); #1;
    check_eq("rmw_run", {29'd0, a_if_en, a_id_en, a_ex_en}, 32'd7);
    check_eq("rmw_cnt_after", a_stall, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
